pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 icache_busy  in  1  instruction fetch miss outstanding (PF/IF).
REQ-004 dcache_busy  in  1  data cache or uncached access outstanding (MEM2).
REQ-005 load_use  in  1  ID instruction needs the result of a load in EX.
REQ-006 div_start  in  1  single-cycle pulse: EX issues a divide.
REQ-007 exc_req  in  1  MEM1 holds an instruction with an exception or eret.
REQ-008 stage write enables (PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr)  out  1 each  1 = the register loads this cycle.
REQ-009 stage flushes (PC_Flush, PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush)  out  1 each  1 = the register clears to its bubble value this cycle.
REQ-010 div_busy  out  1  divide stall active.
REQ-011 DIV_CYCLES  parameter, default 32  divide stall length in cycles.

Function
REQ-012 State machine states: RUN, FLUSH_PEND, REFILL. Register div_cnt is 6 bits wide.
REQ-013 In RUN with no stall source active, every *Wr output is 1 and every *_Flush output is 0.
REQ-014 Priority, highest first: pending or new exception flush, dcache_busy, divide stall, load_use, icache_busy.
REQ-015 dcache_busy=1: all *Wr outputs are 0 and all *_Flush outputs are 0 (full freeze).
REQ-016 Divide stall (div_busy=1): PC_Wr, PF_IFWr, IF_IDWr and ID_EXWr are 0; EX_Flush is 1, which inserts a bubble into EX_MEM1; MEM1_MEM2Wr and MEM2_WBWr are 1.
REQ-017 When div_start=1 in a cycle with dcache_busy=0 and no flush, div_cnt loads DIV_CYCLES on the next edge.
REQ-018 div_busy = (div_cnt != 0). The counter decrements by 1 per cycle while dcache_busy=0, holds while dcache_busy=1, and saturates at 0.
REQ-019 load_use=1 with no higher-priority source active: PC_Wr, PF_IFWr and IF_IDWr are 0; ID_Flush is 1; later stages advance.
REQ-020 icache_busy=1 with no higher-priority source active: PC_Wr and PF_IFWr are 0; IF_Flush is 1; later stages advance.
REQ-021 exc_req=1 in RUN with dcache_busy=0, same cycle: PF_Flush, IF_Flush, ID_Flush and EX_Flush are 1; MEM1_MEM2Wr and MEM2_WBWr are 1; PC_Wr is 1 (redirect); div_cnt clears to 0. Next state is REFILL.
REQ-022 exc_req=1 in RUN with dcache_busy=1: full freeze per REQ-015. Next state is FLUSH_PEND.
REQ-023 FLUSH_PEND: hold the full freeze while dcache_busy=1. In the first cycle with dcache_busy=0, assert the REQ-021 flush pattern regardless of exc_req, then go to REFILL.
REQ-024 REFILL lasts exactly one cycle and has the RUN rules. exc_req in REFILL is ignored (it is the stale, already-flushed instruction). Next state is RUN.
REQ-025 MEM1_Flush, MEM2_Flush and PC_Flush are 0 in every non-reset cycle; the excepting instruction retires with its flag.
REQ-026 No output pair (X_Wr=1 and X_Flush=1) ever occurs for the same stage register outside reset.
REQ-027 div_start in the same cycle as an exception flush is ignored and div_cnt stays 0.
REQ-028 Outputs are combinational from state, div_cnt and the inputs. Latency from an input to its stall or flush response is 0 cycles.

Reset
REQ-029 While rst=1: state is RUN, div_cnt is 0, all *Wr outputs are 0, all *_Flush outputs are 1, and div_busy is 0.
REQ-030 Reset asserted mid-divide or in FLUSH_PEND abandons the operation; the first cycle after rst falls follows the RUN rules.

Structure
REQ-031 A shared package holds the state encoding (RUN=2'd0, FLUSH_PEND=2'd1, REFILL=2'd2), the DIV_CYCLES default and the boot PC constant 32'hbfc0_0000.
REQ-032 One sub-module, div_stall_cnt, implements REQ-017, REQ-018 and REQ-027. It has inputs clk, rst, start, hold and clear, and output busy. All other logic is flat.

Verification
REQ-033 Pulse rst for 2 cycles then release, no other inputs: during reset all Wr=0 and all Flush=1; first cycle after release all Wr=1 and all Flush=0.
REQ-034 div_start=1 for one cycle, DIV_CYCLES=32, other inputs 0: div_busy=1 for exactly 32 cycles and EX_Flush=1 in each of them; PC_Wr=1 on the 33rd cycle.
REQ-035 dcache_busy=1 for 5 cycles starting 10 cycles into a divide: div_cnt holds for those 5 cycles; div_busy stays 1 for a total of 37 cycles.
REQ-036 exc_req=1 and dcache_busy=1 for 3 cycles, with exc_req dropping after cycle 1: state is FLUSH_PEND; on cycle 4 PF_Flush through EX_Flush are 1 and PC_Wr=1; cycle 5 is REFILL; cycle 6 is RUN.
REQ-037 load_use=1 and icache_busy=1 together for one cycle: ID_Flush=1, IF_Flush=0, PC_Wr=0, EX_MEM1Wr=1.
REQ-038 exc_req=1 in the same cycle as div_start=1: the flush pattern of REQ-021 appears; div_busy stays 0 in the following cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encoding,
// divide-stall defaults, boot PC and stage indexing helpers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StFlushPend = 2'd1,
        StRefill    = 2'd2
    } state_e;

    localparam int unsigned DivCyclesDefault = 32;
    localparam int unsigned DivCntWidth      = 6;
    localparam logic [31:0] BootPc           = 32'hbfc0_0000;

    // Stage registers in pipeline order; bit i of a stage vector is register i.
    localparam int unsigned NumStages = 7;
    localparam int unsigned StgPc     = 0;
    localparam int unsigned StgPf     = 1;
    localparam int unsigned StgIf     = 2;
    localparam int unsigned StgId     = 3;
    localparam int unsigned StgEx     = 4;
    localparam int unsigned StgMem1   = 5;
    localparam int unsigned StgMem2   = 6;

    typedef logic [NumStages-1:0] stage_vec_t;

    function automatic stage_vec_t stage_bit(int unsigned stg);
        stage_vec_t v;
        v = '0;
        v[stg] = 1'b1;
        return v;
    endfunction

    // Registers upstream of stg (exclusive): these hold while stg takes a bubble.
    function automatic stage_vec_t upstream_of(int unsigned stg);
        stage_vec_t v;
        v = '0;
        for (int unsigned i = 0; i < NumStages; i++) begin
            if (i < stg) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall sources in, per-stage write enables and flushes out.
// slave = controller side, master = pipeline side.
interface pipe_ctrl_if;

    logic icache_busy;
    logic dcache_busy;
    logic load_use;
    logic div_start;
    logic exc_req;

    logic PC_Wr;
    logic PF_IFWr;
    logic IF_IDWr;
    logic ID_EXWr;
    logic EX_MEM1Wr;
    logic MEM1_MEM2Wr;
    logic MEM2_WBWr;

    logic PC_Flush;
    logic PF_Flush;
    logic IF_Flush;
    logic ID_Flush;
    logic EX_Flush;
    logic MEM1_Flush;
    logic MEM2_Flush;

    logic div_busy;

    modport master (
        output icache_busy, dcache_busy, load_use, div_start, exc_req,
        input  PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr,
        input  PC_Flush, PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush,
        input  div_busy
    );

    modport slave (
        input  icache_busy, dcache_busy, load_use, div_start, exc_req,
        output PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr,
        output PC_Flush, PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush,
        output div_busy
    );

endinterface

// File: rtl/div_stall_cnt.sv
// Divide stall counter: loads DIV_CYCLES on start, counts down unless held,
// and is wiped by an exception flush.
module div_stall_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DivCyclesDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    input  logic clear,
    output logic busy
);

    localparam logic [DivCntWidth-1:0] LoadVal = DivCntWidth'(DIV_CYCLES);

    logic [DivCntWidth-1:0] div_cnt_q, div_cnt_d;

    // clear wins over start so a divide issued alongside a flush is dropped.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (!hold) begin
            if (start) begin
                div_cnt_d = LoadVal;
            end else if (div_cnt_q != '0) begin
                div_cnt_d = div_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign busy = (div_cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritises exception flush, data-cache freeze,
// divide stall, load-use and fetch stalls into per-stage write/flush strobes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DivCyclesDefault
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    pipe_io
);

    state_e     state_q, state_d;
    stage_vec_t wr, fl;
    logic       flush_now;
    logic       div_clear;
    logic       div_cnt_busy;

    // A pending flush fires the first cycle the data side is free; REFILL
    // ignores exc_req because MEM1 still holds the already-flushed instruction.
    assign flush_now = !pipe_io.dcache_busy &&
                       ((state_q == StRun && pipe_io.exc_req) || state_q == StFlushPend);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (pipe_io.exc_req) begin
                    state_d = pipe_io.dcache_busy ? StFlushPend : StRefill;
                end
            end
            StFlushPend: begin
                if (!pipe_io.dcache_busy) state_d = StRefill;
            end
            StRefill: state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        wr        = '1;
        fl        = '0;
        div_clear = 1'b0;
        if (rst) begin
            wr = '0;
            fl = '1;
        end else if (flush_now) begin
            // PC redirects; PF..EX squashed; MEM1/MEM2 carry the excepting op out.
            fl        = stage_bit(StgPf) | stage_bit(StgIf) | stage_bit(StgId) | stage_bit(StgEx);
            wr        = ~fl;
            div_clear = 1'b1;
        end else if (pipe_io.dcache_busy) begin
            wr = '0;
        end else if (div_cnt_busy) begin
            fl = stage_bit(StgEx);
            wr = ~(fl | upstream_of(StgEx));
        end else if (pipe_io.load_use) begin
            fl = stage_bit(StgId);
            wr = ~(fl | upstream_of(StgId));
        end else if (pipe_io.icache_busy) begin
            fl = stage_bit(StgIf);
            wr = ~(fl | upstream_of(StgIf));
        end
    end

    div_stall_cnt #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .start (pipe_io.div_start),
        .hold  (pipe_io.dcache_busy),
        .clear (div_clear),
        .busy  (div_cnt_busy)
    );

    assign pipe_io.div_busy    = div_cnt_busy & ~rst;

    assign pipe_io.PC_Wr       = wr[StgPc];
    assign pipe_io.PF_IFWr     = wr[StgPf];
    assign pipe_io.IF_IDWr     = wr[StgIf];
    assign pipe_io.ID_EXWr     = wr[StgId];
    assign pipe_io.EX_MEM1Wr   = wr[StgEx];
    assign pipe_io.MEM1_MEM2Wr = wr[StgMem1];
    assign pipe_io.MEM2_WBWr   = wr[StgMem2];

    assign pipe_io.PC_Flush    = fl[StgPc];
    assign pipe_io.PF_Flush    = fl[StgPf];
    assign pipe_io.IF_Flush    = fl[StgIf];
    assign pipe_io.ID_Flush    = fl[StgId];
    assign pipe_io.EX_Flush    = fl[StgEx];
    assign pipe_io.MEM1_Flush  = fl[StgMem1];
    assign pipe_io.MEM2_Flush  = fl[StgMem2];

    no_wr_and_flush: assert property (@(posedge clk) disable iff (rst) (wr & fl) == '0);
    no_tail_flush: assert property (@(posedge clk) disable iff (rst)
        !fl[StgPc] && !fl[StgMem1] && !fl[StgMem2]);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised + directed bench for pipe_ctrl with a queue-based scoreboard
// fed by a per-stage advance/hold/bubble reference model.
module tb_pipe_ctrl;

    localparam int unsigned Div = 32;

    typedef struct {
        logic [14:0] v;      // {div_busy, wr[6:0], fl[6:0]}, bit i = stage i
        bit          in_rst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if pif ();

    pipe_ctrl #(
        .DIV_CYCLES (Div)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pipe_io (pif)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   busy_seen = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    // Reference model state
    int m_div_left = 0;
    bit m_pend = 1'b0;
    bit m_refill = 1'b0;

    logic [6:0] act_wr, act_fl;
    assign act_wr = {pif.MEM2_WBWr, pif.MEM1_MEM2Wr, pif.EX_MEM1Wr, pif.ID_EXWr,
                     pif.IF_IDWr, pif.PF_IFWr, pif.PC_Wr};
    assign act_fl = {pif.MEM2_Flush, pif.MEM1_Flush, pif.EX_Flush, pif.ID_Flush,
                     pif.IF_Flush, pif.PF_Flush, pif.PC_Flush};

    initial begin
        pif.icache_busy = 1'b0;
        pif.dcache_busy = 1'b0;
        pif.load_use    = 1'b0;
        pif.div_start   = 1'b0;
        pif.exc_req     = 1'b0;
    end

    // Monitor: compare the DUT against the oldest expectation, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [14:0] got;
        cyc++;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {pif.div_busy, act_wr, act_fl};
            tests++;
            if (got !== e.v) begin
                fails++;
                $display("FAIL outputs cycle %0d: got busy/wr/fl=%b want %b", cyc, got, e.v);
            end
            if (!e.in_rst) begin
                tests++;
                if ((act_wr & act_fl) != 7'd0) begin
                    fails++;
                    $display("FAIL wr_flush_pair cycle %0d: got %b want 0000000", cyc,
                             act_wr & act_fl);
                end
            end
            if (pif.div_busy === 1'b1) busy_seen++;
        end
    end

    // Drive one cycle of inputs and queue what the pipeline should do with them.
    // Stage action: 0 = advance, 1 = hold, 2 = bubble.
    task automatic step(input bit r, input bit ic, input bit dc, input bit lu,
                        input bit ds, input bit ex);
        int   act [7];
        int   bub;
        bit   exc_eff, do_flush;
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        pif.icache_busy = ic;
        pif.dcache_busy = dc;
        pif.load_use    = lu;
        pif.div_start   = ds;
        pif.exc_req     = ex;
        for (int i = 0; i < 7; i++) act[i] = 0;
        e.in_rst = r;
        e.v      = '0;
        if (r) begin
            for (int i = 0; i < 7; i++) act[i] = 2;
            m_div_left = 0;
            m_pend     = 1'b0;
            m_refill   = 1'b0;
        end else begin
            exc_eff  = ex && !m_refill;
            do_flush = !dc && (m_pend || exc_eff);
            e.v[14]  = (m_div_left > 0);
            bub = -1;
            if (do_flush) begin
                for (int i = 1; i <= 4; i++) act[i] = 2;
            end else if (dc) begin
                for (int i = 0; i < 7; i++) act[i] = 1;
            end else if (m_div_left > 0) bub = 4;
            else if (lu) bub = 3;
            else if (ic) bub = 2;
            if (bub >= 0) begin
                for (int i = 0; i < bub; i++) act[i] = 1;
                act[bub] = 2;
            end
            if (do_flush) begin
                m_div_left = 0;
                m_pend     = 1'b0;
                m_refill   = 1'b1;
            end else begin
                m_refill = 1'b0;
                if (dc) m_pend = m_pend | exc_eff;
                else if (ds) m_div_left = Div;
                else if (m_div_left > 0) m_div_left--;
            end
        end
        for (int i = 0; i < 7; i++) begin
            e.v[7 + i] = (act[i] == 0);
            e.v[i]     = (act[i] == 2);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_busy_len(input string name, input int base, input int want);
        @(negedge clk);
        #1;
        tests++;
        if (busy_seen - base != want) begin
            fails++;
            $display("FAIL %s: got %0d busy cycles want %0d", name, busy_seen - base, want);
        end
    endtask

    initial begin
        int b0;
        // Reset pulse then release
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(3);

        // Single divide
        b0 = busy_seen;
        step(0, 0, 0, 0, 1, 0);
        idle(40);
        check_busy_len("div_len", b0, 32);

        // Divide with a 5-cycle dcache freeze ten cycles in
        b0 = busy_seen;
        step(0, 0, 0, 0, 1, 0);
        idle(10);
        repeat (5) step(0, 0, 1, 0, 0, 0);
        idle(30);
        check_busy_len("div_hold_len", b0, 37);

        // Exception behind a busy dcache, then flush, refill, run
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(3);

        // exc_req held through REFILL must not re-flush
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);

        // load_use beats icache_busy
        step(0, 1, 0, 1, 0, 0);
        idle(1);

        // Divide issued with an exception is dropped
        b0 = busy_seen;
        step(0, 0, 0, 0, 1, 1);
        idle(3);
        check_busy_len("div_with_exc", b0, 0);

        // Reset mid-divide
        step(0, 0, 0, 0, 1, 0);
        idle(4);
        step(1, 0, 0, 0, 0, 0);
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 11) == 0));
        end
        idle(2);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
